// File: rtl/measure_sequencer.sv
// Display-latency measurement sequencer: arms a flash on a video frame and waits
// for the light sensor's rising edge, a timeout, or an abort, then cools down.
module measure_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES  = 27000000,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        enable,
    input  logic        sensor_input,
    input  logic [7:0]  config_data,
    output logic        flash_on,
    output logic        reset_counter,
    output logic        sensor_trigger,
    output logic        reset_bcdoutput,
    output logic        timeout,
    output logic [15:0] measure_count,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] COOL_DONE  = CW'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        COOLDOWN
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] cool_count;
    logic [7:0]    prev_config;
    logic          s1;
    logic          s2;
    logic          s3;
    logic          sensor_edge;
    logic          config_change;

    assign sensor_edge   = s2 & ~s3;
    assign config_change = (config_data != prev_config);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state           <= IDLE;
            flash_on        <= 1'b0;
            reset_counter   <= 1'b0;
            sensor_trigger  <= 1'b0;
            reset_bcdoutput <= 1'b0;
            timeout         <= 1'b0;
            busy            <= 1'b0;
            measure_count   <= '0;
            timer           <= '0;
            cool_count      <= '0;
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            prev_config     <= config_data;
        end else begin
            s1              <= sensor_input;
            s2              <= s1;
            s3              <= s2;
            prev_config     <= config_data;
            reset_counter   <= 1'b0;
            sensor_trigger  <= 1'b0;
            reset_bcdoutput <= config_change;
            if (config_change) begin
                measure_count <= '0;
            end

            case (state)
                IDLE: begin
                    if (frame_start && enable) begin
                        state         <= MEASURE;
                        flash_on      <= 1'b1;
                        reset_counter <= 1'b1;
                        timeout       <= 1'b0;
                        timer         <= '0;
                        busy          <= 1'b1;
                    end
                end

                MEASURE: begin
                    timer <= timer + TW'(1);
                    // Abort (config change or enable drop) outranks a success,
                    // which outranks the timeout.
                    if (config_change || !enable) begin
                        flash_on   <= 1'b0;
                        state      <= COOLDOWN;
                        cool_count <= '0;
                    end else if (sensor_edge) begin
                        sensor_trigger <= 1'b1;
                        if (measure_count != '1) begin
                            measure_count <= measure_count + 16'd1;
                        end
                        flash_on   <= 1'b0;
                        state      <= COOLDOWN;
                        cool_count <= '0;
                    end else if (timer == TIMER_LAST) begin
                        timeout    <= 1'b1;
                        flash_on   <= 1'b0;
                        state      <= COOLDOWN;
                        cool_count <= '0;
                    end
                end

                COOLDOWN: begin
                    // Stay here while the sensor still sees light so a lingering
                    // flash cannot bleed into the next measurement.
                    if ((cool_count == COOL_DONE) && !s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_start && (cool_count != COOL_DONE)) begin
                        cool_count <= cool_count + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    flash_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_measure_sequencer.sv
// Directed bench for measure_sequencer with a short timeout and cooldown so every
// path (success, timeout, abort, cooldown hold, reset) is reachable quickly.
module tb_measure_sequencer;

    logic        clock;
    logic        resetn;
    logic        frame_start;
    logic        enable;
    logic        sensor_input;
    logic [7:0]  config_data;
    logic        flash_on;
    logic        reset_counter;
    logic        sensor_trigger;
    logic        reset_bcdoutput;
    logic        timeout;
    logic [15:0] measure_count;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    measure_sequencer #(
        .TIMEOUT_CYCLES (50),
        .COOLDOWN_FRAMES(4)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .frame_start    (frame_start),
        .enable         (enable),
        .sensor_input   (sensor_input),
        .config_data    (config_data),
        .flash_on       (flash_on),
        .reset_counter  (reset_counter),
        .sensor_trigger (sensor_trigger),
        .reset_bcdoutput(reset_bcdoutput),
        .timeout        (timeout),
        .measure_count  (measure_count),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        frame_start  = 1'b0;
        enable       = 1'b1;
        sensor_input = 1'b0;
        config_data  = 8'h01;
        cyc();
        cyc();
        chk1("rst_flash", flash_on, 1'b0);
        chk1("rst_rc", reset_counter, 1'b0);
        chk1("rst_trig", sensor_trigger, 1'b0);
        chk1("rst_rbcd", reset_bcdoutput, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_count", measure_count, 16'd0);
        resetn = 1'b1;
        cyc();
        chk1("post_rst_rbcd", reset_bcdoutput, 1'b0);
        chk1("post_rst_busy", busy, 1'b0);

        // Successful measurement, frame_start ignored while measuring
        pulse_frame();
        chk1("a_flash_on", flash_on, 1'b1);
        chk1("a_rc_first", reset_counter, 1'b1);
        chk1("a_busy", busy, 1'b1);
        cyc();
        chk1("a_rc_second", reset_counter, 1'b0);
        chk1("a_flash_hold", flash_on, 1'b1);
        pulse_frame();
        chk1("a_frame_ignored_rc", reset_counter, 1'b0);
        chk1("a_frame_ignored_flash", flash_on, 1'b1);
        repeat (8) cyc();
        sensor_input = 1'b1;
        cyc();
        cyc();
        chk1("a_trig_early", sensor_trigger, 1'b0);
        cyc();
        chk1("a_trig", sensor_trigger, 1'b1);
        chk16("a_count", measure_count, 16'd1);
        chk1("a_flash_off", flash_on, 1'b0);
        chk1("a_busy_cool", busy, 1'b1);
        cyc();
        chk1("a_trig_single", sensor_trigger, 1'b0);
        sensor_input = 1'b0;
        cyc();
        cyc();
        repeat (3) begin
            pulse_frame();
            cyc();
        end
        chk1("a_busy_3frames", busy, 1'b1);
        pulse_frame();
        chk1("a_busy_4frames", busy, 1'b1);
        cyc();
        chk1("a_idle", busy, 1'b0);

        // Sensor edge in IDLE is ignored
        sensor_input = 1'b1;
        cyc();
        cyc();
        cyc();
        chk1("idle_edge_trig", sensor_trigger, 1'b0);
        chk1("idle_edge_busy", busy, 1'b0);
        cyc();
        chk16("idle_edge_count", measure_count, 16'd1);
        sensor_input = 1'b0;
        repeat (3) cyc();

        // Timeout after 50 MEASURE cycles
        pulse_frame();
        repeat (49) cyc();
        chk1("b_timeout_pre", timeout, 1'b0);
        chk1("b_flash_pre", flash_on, 1'b1);
        cyc();
        chk1("b_timeout", timeout, 1'b1);
        chk1("b_flash_off", flash_on, 1'b0);
        chk16("b_count", measure_count, 16'd1);
        chk1("b_busy", busy, 1'b1);
        repeat (4) pulse_frame();
        cyc();
        chk1("b_idle", busy, 1'b0);
        chk1("b_timeout_sticky", timeout, 1'b1);
        pulse_frame();
        chk1("b_timeout_cleared", timeout, 1'b0);
        chk1("b_restart_flash", flash_on, 1'b1);
        chk1("b_restart_rc", reset_counter, 1'b1);

        // Config change coincident with a sensor edge aborts the measurement
        sensor_input = 1'b1;
        cyc();
        cyc();
        config_data = 8'h02;
        cyc();
        chk1("c_rbcd", reset_bcdoutput, 1'b1);
        chk1("c_no_trig", sensor_trigger, 1'b0);
        chk16("c_count_clr", measure_count, 16'd0);
        chk1("c_flash_off", flash_on, 1'b0);
        chk1("c_busy", busy, 1'b1);
        chk1("c_timeout", timeout, 1'b0);
        cyc();
        chk1("c_rbcd_single", reset_bcdoutput, 1'b0);
        chk1("c_no_trig_late", sensor_trigger, 1'b0);

        // Sensor held high keeps COOLDOWN past its frame count
        repeat (7) pulse_frame();
        chk1("d_hold", busy, 1'b1);
        sensor_input = 1'b0;
        cyc();
        chk1("d_hold_s1", busy, 1'b1);
        cyc();
        chk1("d_hold_s2fall", busy, 1'b1);
        cyc();
        chk1("d_exit", busy, 1'b0);

        // Back-to-back config changes
        config_data = 8'h03;
        cyc();
        chk1("e_rbcd_1", reset_bcdoutput, 1'b1);
        config_data = 8'h04;
        cyc();
        chk1("e_rbcd_2", reset_bcdoutput, 1'b1);
        cyc();
        chk1("e_rbcd_0", reset_bcdoutput, 1'b0);
        chk16("e_count", measure_count, 16'd0);

        // enable: blocks entry, aborts MEASURE, leaves COOLDOWN alone
        enable = 1'b0;
        pulse_frame();
        chk1("f_blocked_busy", busy, 1'b0);
        chk1("f_blocked_rc", reset_counter, 1'b0);
        enable = 1'b1;
        pulse_frame();
        chk1("f_start_busy", busy, 1'b1);
        chk1("f_start_rc", reset_counter, 1'b1);
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        chk1("f_abort_flash", flash_on, 1'b0);
        chk1("f_abort_busy", busy, 1'b1);
        chk1("f_abort_rbcd", reset_bcdoutput, 1'b0);
        chk1("f_abort_timeout", timeout, 1'b0);
        repeat (4) pulse_frame();
        cyc();
        chk1("f_cool_exit", busy, 1'b0);
        enable = 1'b1;

        // Sensor edge on the timeout cycle counts as success
        pulse_frame();
        repeat (47) cyc();
        sensor_input = 1'b1;
        cyc();
        cyc();
        chk1("g_trig_pre", sensor_trigger, 1'b0);
        chk1("g_flash_pre", flash_on, 1'b1);
        cyc();
        chk1("g_trig", sensor_trigger, 1'b1);
        chk1("g_no_timeout", timeout, 1'b0);
        chk16("g_count", measure_count, 16'd1);
        chk1("g_flash_off", flash_on, 1'b0);
        sensor_input = 1'b0;
        repeat (3) cyc();
        sensor_input = 1'b1;
        repeat (3) cyc();
        chk1("g_cool_edge_trig", sensor_trigger, 1'b0);
        cyc();
        chk16("g_cool_edge_count", measure_count, 16'd1);
        sensor_input = 1'b0;
        repeat (3) cyc();
        repeat (4) pulse_frame();
        cyc();
        chk1("g_idle", busy, 1'b0);

        // Reset in the middle of MEASURE
        pulse_frame();
        cyc();
        chk1("h_flash_pre", flash_on, 1'b1);
        chk1("h_busy_pre", busy, 1'b1);
        config_data = 8'h05;
        resetn      = 1'b0;
        cyc();
        chk1("h_flash", flash_on, 1'b0);
        chk1("h_rc", reset_counter, 1'b0);
        chk1("h_trig", sensor_trigger, 1'b0);
        chk1("h_rbcd", reset_bcdoutput, 1'b0);
        chk1("h_timeout", timeout, 1'b0);
        chk1("h_busy", busy, 1'b0);
        chk16("h_count", measure_count, 16'd0);
        resetn = 1'b1;
        cyc();
        chk1("h_post_rbcd", reset_bcdoutput, 1'b0);
        chk1("h_post_busy", busy, 1'b0);
        chk1("h_post_flash", flash_on, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
